// File: rtl/wb_queue_pkg.sv
// Shared defaults and entry layout for the register-file writeback queue.
package wb_queue_pkg;

    localparam int WBQ_DEPTH = 4;
    localparam int WBQ_DW    = 32;
    localparam int WBQ_AW    = 5;

    // One pending register-file write.
    typedef struct packed {
        logic [WBQ_AW-1:0] rg;
        logic [WBQ_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue_if.sv
// Producer handshakes, register-file write port and bypass lookups of the writeback queue.
interface wb_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
);
    logic                     mem_valid;
    logic                     mem_ready;
    logic [AW-1:0]            mem_reg;
    logic [DW-1:0]            mem_data;
    logic                     alu_valid;
    logic                     alu_ready;
    logic [AW-1:0]            alu_reg;
    logic [DW-1:0]            alu_data;
    logic                     hold;
    logic                     we;
    logic [AW-1:0]            wreg;
    logic [DW-1:0]            wdata;
    logic [AW-1:0]            q_rreg1;
    logic [AW-1:0]            q_rreg2;
    logic                     q_hit1;
    logic                     q_hit2;
    logic [DW-1:0]            q_data1;
    logic [DW-1:0]            q_data2;
    logic [$clog2(DEPTH):0]   count;
    logic                     empty;

    modport slave (
        input  mem_valid, mem_reg, mem_data,
        input  alu_valid, alu_reg, alu_data,
        input  hold, q_rreg1, q_rreg2,
        output mem_ready, alu_ready,
        output we, wreg, wdata,
        output q_hit1, q_hit2, q_data1, q_data2,
        output count, empty
    );

    modport master (
        output mem_valid, mem_reg, mem_data,
        output alu_valid, alu_reg, alu_data,
        output hold, q_rreg1, q_rreg2,
        input  mem_ready, alu_ready,
        input  we, wreg, wdata,
        input  q_hit1, q_hit2, q_data1, q_data2,
        input  count, empty
    );
endinterface

// File: rtl/wb_queue_match.sv
// Youngest-first lookup over the queued entries plus the registered output stage.
module wb_match #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [PW-1:0]             head,
    input  logic [DEPTH-1:0]          vld,
    input  logic [DEPTH-1:0][AW-1:0]  ent_rg,
    input  logic [DEPTH-1:0][DW-1:0]  ent_data,
    input  logic                      out_we,
    input  logic [AW-1:0]             out_reg,
    input  logic [DW-1:0]             out_data,
    input  logic [AW-1:0]             q_reg,
    output logic                      hit,
    output logic [DW-1:0]             data
);

    logic          hit_raw;
    logic [DW-1:0] data_raw;
    logic [PW-1:0] idx;

    // Walk oldest to youngest so the last match seen is the youngest one;
    // the output stage is older than anything still queued.
    always_comb begin
        hit_raw  = 1'b0;
        data_raw = '0;
        idx      = '0;
        if (out_we && out_reg == q_reg) begin
            hit_raw  = 1'b1;
            data_raw = out_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (vld[idx] && ent_rg[idx] == q_reg) begin
                hit_raw  = 1'b1;
                data_raw = ent_data[idx];
            end
        end
    end

    assign hit  = hit_raw && (q_reg != '0);
    assign data = hit ? data_raw : '0;

endmodule

// File: rtl/wb_queue.sv
// Program-ordered writeback queue draining one write per cycle into the register file.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH,
    parameter int DW    = WBQ_DW,
    parameter int AW    = WBQ_AW
) (
    input  logic    clk,
    input  logic    rst_n,
    wb_queue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t              ents_q [DEPTH];
    logic [DEPTH-1:0]       vld_q;
    logic [PW-1:0]          head_q;
    logic [PW-1:0]          tail_q;
    logic [CW-1:0]          count_q;
    logic                   we_q;
    logic [AW-1:0]          wreg_q;
    logic [DW-1:0]          wdata_q;

    logic [CW-1:0]          free;
    logic                   mem_xfer, alu_xfer;
    logic                   mem_push, alu_push;
    logic                   pop;
    logic [PW-1:0]          alu_slot;

    // Readiness comes from the current occupancy only; a same-cycle pop earns no credit.
    assign free          = CW'(DEPTH) - count_q;
    assign bus.mem_ready = (free != '0);
    assign bus.alu_ready = (free >= CW'(2)) || ((free != '0) && !bus.mem_valid);

    assign mem_xfer = bus.mem_valid && bus.mem_ready;
    assign alu_xfer = bus.alu_valid && bus.alu_ready;
    // Writes to $0 finish the handshake but never occupy a slot.
    assign mem_push = mem_xfer && (bus.mem_reg != '0);
    assign alu_push = alu_xfer && (bus.alu_reg != '0);
    assign pop      = (count_q != '0) && !bus.hold;
    assign alu_slot = tail_q + PW'(mem_push);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (pop) begin
                we_q          <= 1'b1;
                wreg_q        <= ents_q[head_q].rg;
                wdata_q       <= ents_q[head_q].data;
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PW'(1);
            end else begin
                we_q <= 1'b0;
            end
            if (mem_push) vld_q[tail_q]   <= 1'b1;
            if (alu_push) vld_q[alu_slot] <= 1'b1;
            tail_q  <= tail_q + PW'(mem_push) + PW'(alu_push);
            count_q <= count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
        end
    end

    // Payload storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (mem_push) ents_q[tail_q]   <= '{rg: bus.mem_reg, data: bus.mem_data};
        if (alu_push) ents_q[alu_slot] <= '{rg: bus.alu_reg, data: bus.alu_data};
    end

    assign bus.we    = we_q;
    assign bus.wreg  = wreg_q;
    assign bus.wdata = wdata_q;
    assign bus.count = count_q;
    assign bus.empty = (count_q == '0) && !we_q;

    logic [DEPTH-1:0][AW-1:0] ent_rg;
    logic [DEPTH-1:0][DW-1:0] ent_data;
    logic [1:0][AW-1:0]       q_rreg;
    logic [1:0]               q_hit;
    logic [1:0][DW-1:0]       q_data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign ent_rg[i]   = ents_q[i].rg;
        assign ent_data[i] = ents_q[i].data;
    end

    assign q_rreg = {bus.q_rreg2, bus.q_rreg1};

    for (genvar p = 0; p < 2; p++) begin : g_lk
        wb_match #(
            .DEPTH (DEPTH),
            .DW    (DW),
            .AW    (AW)
        ) u_match (
            .head     (head_q),
            .vld      (vld_q),
            .ent_rg   (ent_rg),
            .ent_data (ent_data),
            .out_we   (we_q),
            .out_reg  (wreg_q),
            .out_data (wdata_q),
            .q_reg    (q_rreg[p]),
            .hit      (q_hit[p]),
            .data     (q_data[p])
        );
    end

    assign bus.q_hit1  = q_hit[0];
    assign bus.q_hit2  = q_hit[1];
    assign bus.q_data1 = q_data[0];
    assign bus.q_data2 = q_data[1];

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: ordering, $0 discard, backpressure, bypass and async reset.
module tb_wb_queue;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    wb_queue_if #(.DEPTH(4), .DW(32), .AW(5)) bus ();

    wb_queue #(.DEPTH(4), .DW(32), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.mem_valid = 0; bus.mem_reg = '0; bus.mem_data = '0;
        bus.alu_valid = 0; bus.alu_reg = '0; bus.alu_data = '0;
        bus.hold = 0; bus.q_rreg1 = 5'd8; bus.q_rreg2 = '0;
        #2;
        chk("rst_we", bus.we, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_mem_ready", bus.mem_ready, 1);
        chk("rst_alu_ready", bus.alu_ready, 1);
        chk("rst_hit1", bus.q_hit1, 0);
        #10 rst_n = 1'b1;

        // Single ALU write
        tick();
        bus.alu_valid = 1; bus.alu_reg = 5'd8; bus.alu_data = 32'h1;
        #1 chk("single_alu_ready", bus.alu_ready, 1);
        tick();
        bus.alu_valid = 0;
        chk("single_count1", bus.count, 1);
        chk("single_we0", bus.we, 0);
        chk("single_hit_q", bus.q_hit1, 1);
        chk("single_data_q", bus.q_data1, 32'h1);
        tick();
        chk("single_we", bus.we, 1);
        chk("single_wreg", bus.wreg, 8);
        chk("single_wdata", bus.wdata, 32'h1);
        chk("single_count0", bus.count, 0);
        chk("single_hit_out", bus.q_hit1, 1);
        tick();
        chk("single_we_off", bus.we, 0);
        chk("single_empty", bus.empty, 1);
        chk("single_hit_gone", bus.q_hit1, 0);
        chk("single_data_gone", bus.q_data1, 0);

        // Dual push: load is older than ALU result
        bus.mem_valid = 1; bus.mem_reg = 5'd9;  bus.mem_data = 32'hA;
        bus.alu_valid = 1; bus.alu_reg = 5'd10; bus.alu_data = 32'hB;
        #1;
        chk("dual_mem_ready", bus.mem_ready, 1);
        chk("dual_alu_ready", bus.alu_ready, 1);
        tick();
        bus.mem_valid = 0; bus.alu_valid = 0;
        chk("dual_count", bus.count, 2);
        tick();
        chk("dual_w1", {bus.we, bus.wreg, bus.wdata}, {1'b1, 5'd9, 32'hA});
        chk("dual_count1", bus.count, 1);
        tick();
        chk("dual_w2", {bus.we, bus.wreg, bus.wdata}, {1'b1, 5'd10, 32'hB});
        chk("dual_count0", bus.count, 0);
        tick();
        chk("dual_we_off", bus.we, 0);

        // $0 discard
        bus.alu_valid = 1; bus.alu_reg = 5'd0; bus.alu_data = 32'hFFFF_FFFF;
        bus.q_rreg1 = 5'd0;
        #1 chk("zero_ready", bus.alu_ready, 1);
        tick();
        bus.alu_valid = 0;
        chk("zero_count", bus.count, 0);
        chk("zero_we_a", bus.we, 0);
        chk("zero_hit", bus.q_hit1, 0);
        tick();
        chk("zero_we_b", bus.we, 0);
        chk("zero_empty", bus.empty, 1);

        // Full / backpressure under hold
        bus.hold = 1;
        bus.mem_valid = 1; bus.mem_reg = 5'd1; bus.mem_data = 32'h11;
        bus.alu_valid = 1; bus.alu_reg = 5'd2; bus.alu_data = 32'h22;
        tick();
        bus.alu_valid = 0;
        bus.mem_reg = 5'd3; bus.mem_data = 32'h33;
        chk("bp_count2", bus.count, 2);
        tick();
        chk("bp_count3", bus.count, 3);
        bus.mem_reg = 5'd4; bus.mem_data = 32'h44;
        bus.alu_valid = 1; bus.alu_reg = 5'd5; bus.alu_data = 32'h55;
        #1;
        chk("bp3_mem_ready", bus.mem_ready, 1);
        chk("bp3_alu_ready", bus.alu_ready, 0);
        tick();
        bus.mem_valid = 0;
        #1;
        chk("bp_count4", bus.count, 4);
        chk("bp4_mem_ready", bus.mem_ready, 0);
        chk("bp4_alu_ready", bus.alu_ready, 0);
        tick();
        chk("bp_hold_we", bus.we, 0);
        chk("bp_hold_count", bus.count, 4);
        bus.alu_valid = 0; bus.hold = 0;
        tick();
        chk("bp_w1", {bus.we, bus.wreg, bus.wdata}, {1'b1, 5'd1, 32'h11});
        chk("bp_w1_count", bus.count, 3);
        tick();
        chk("bp_w2", {bus.we, bus.wreg, bus.wdata}, {1'b1, 5'd2, 32'h22});
        tick();
        chk("bp_w3", {bus.we, bus.wreg, bus.wdata}, {1'b1, 5'd3, 32'h33});
        tick();
        chk("bp_w4", {bus.we, bus.wreg, bus.wdata}, {1'b1, 5'd4, 32'h44});
        chk("bp_w4_count", bus.count, 0);
        tick();
        chk("bp_done_empty", bus.empty, 1);

        // Bypass priority: youngest of two writes to r13
        bus.hold = 1;
        bus.alu_valid = 1; bus.alu_reg = 5'd13; bus.alu_data = 32'h20;
        tick();
        bus.alu_data = 32'h30;
        tick();
        bus.alu_valid = 0;
        bus.q_rreg1 = 5'd13; bus.q_rreg2 = 5'd0;
        #1;
        chk("byp_hit1", bus.q_hit1, 1);
        chk("byp_data1", bus.q_data1, 32'h30);
        chk("byp_hit2", bus.q_hit2, 0);
        chk("byp_data2", bus.q_data2, 0);
        bus.hold = 0;
        tick();
        chk("byp_w1", {bus.we, bus.wreg, bus.wdata}, {1'b1, 5'd13, 32'h20});
        chk("byp_data_mid", bus.q_data1, 32'h30);
        tick();
        chk("byp_w2", {bus.we, bus.wreg, bus.wdata}, {1'b1, 5'd13, 32'h30});
        chk("byp_out_hit", {bus.q_hit1, bus.q_data1}, {1'b1, 32'h30});
        tick();
        chk("byp_drained_hit", bus.q_hit1, 0);

        // Async reset mid-drain
        bus.hold = 1;
        bus.mem_valid = 1; bus.mem_reg = 5'd20; bus.mem_data = 32'h200;
        bus.alu_valid = 1; bus.alu_reg = 5'd21; bus.alu_data = 32'h210;
        tick();
        bus.mem_reg = 5'd22; bus.mem_data = 32'h220;
        bus.alu_reg = 5'd23; bus.alu_data = 32'h230;
        tick();
        bus.mem_valid = 0; bus.alu_valid = 0; bus.hold = 0;
        bus.q_rreg1 = 5'd21;
        tick();
        chk("ar_pre_we", bus.we, 1);
        chk("ar_pre_count", bus.count, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_we", bus.we, 0);
        chk("ar_count", bus.count, 0);
        chk("ar_empty", bus.empty, 1);
        chk("ar_hit", {bus.q_hit1, bus.q_data1}, {1'b0, 32'h0});
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        chk("ar_post_we1", bus.we, 0);
        tick();
        chk("ar_post_we2", bus.we, 0);
        tick();
        chk("ar_post_we3", bus.we, 0);
        chk("ar_post_count", bus.count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
